id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised decode stage for the 16-bit-instruction pipelined CPU. It sits between the IF/ID and EX stages and contains the register file, main control decode and branch resolution. Unlike the earlier decode block, it also owns the ID/EX pipeline register, a load-use hazard interlock, wrong-path squash after taken branches, and a halt state machine. Datapath width and register count are generic; the instruction encoding is fixed at 16 bits.

## Interface
- DATA_W, 16, datapath and PC width (≥16)
- NREG, 16, architectural registers; register fields are 4 bits, so NREG ≤ 16; indices ≥ NREG read 0 and ignore writes
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  16  IF/ID instruction
- pc_plus2  in  DATA_W  IF/ID PC+2
- id_valid  in  1  IF/ID slot holds a real instruction
- flags  in  3  {N,V,Z}: flags[2]=N, flags[1]=V, flags[0]=Z; valid in the decode cycle
- wb_we  in  1  write-back enable
- wb_dst  in  4  write-back register
- wb_data  in  DATA_W  write-back data
- stall_out  out  1  combinational; upstream holds instr/pc_plus2 while high
- ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_alusrc, ex_llb, ex_lhb  out  1 each  registered control
- ex_aluop  out  4  registered opcode
- ex_dst  out  4  registered instr[11:8]
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands and sign-extended immediate
- branch_taken  out  1  registered one-cycle pulse
- branch_target  out  DATA_W  registered target, valid while branch_taken=1
- halted  out  1  registered; high in HALT

## Operation
- Register file: NREG×DATA_W. R0 reads 0 and writes to it are ignored. Write-through: a read of wb_dst while wb_we=1 returns wb_data in the same cycle.
- Source selection:
  - rs field = instr[7:4], except LLB/LHB (1010/1011), which use instr[11:8].
  - rt field = instr[3:0], except LW/SW (100x), which use instr[11:8].
- Sources used, for hazard checking:
  - 0000–0011, 0111: rs and rt.
  - 0100–0110, LW, BR(1101), LLB, LHB: rs only.
  - SW: rs and rt.
  - B(1100), PCS(1110), HLT(1111): none.
- Control decode:
  - RegWrite: 0000–1000, 1010, 1011, 1110.
  - ALUSrc: 0100–0110, 1000–1011.
  - LW sets MemRead and MemToReg. SW sets MemWrite.
  - ex_llb / ex_lhb are set for 1010 / 1011 respectively.
- Immediate: opcodes 0100–0110 and 1000–1001 use sign-extend(instr[3:0]); all others use sign-extend(instr[7:0]). Both extend to DATA_W.
- Branch conditions:
  - Applies to B and BR, selected by cond = instr[11:9].
  - 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|N=0; 101 Z=1|N=1; 110 V=1; 111 always.
- Branch target:
  - B: pc_plus2 + (sign-extend(instr[8:0]) << 1), modulo 2^DATA_W.
  - BR: the rs read data.
- Effective validity: eff = id_valid & ~branch_taken & ~halted.
  - The slot after a taken branch is squashed: it becomes a bubble, and it raises no stall, branch or halt.
- Load-use interlock: stall_out = eff & ex_valid & ex_memread & (ex_dst ≠ 0) & (ex_dst equals a used source field). This does not depend on id_valid alone.
- Halt also drives stall_out: stall_out = 1 while halted=1.
- ID/EX load each edge:
  - If eff & ~stall_out: load the decoded instruction with ex_valid=1.
  - Otherwise: load a bubble. All ex_* control = 0, ex_valid = 0; data fields may hold any value.
- Branch pulse: branch_taken ← eff & ~stall_out & (B|BR) & cond. A stalled BR resolves in the cycle its stall clears, using that cycle's flags.
- State machine:
  - RUN → HALT when eff & ~stall_out & opcode=1111.
  - HALT is sticky until rst.
  - The HLT itself enters ID/EX with ex_valid=1 and RegWrite=0.

## Timing
- Latency: the instruction accepted at edge k is on ex_* after edge k. branch_taken/branch_target change after the same edge k.
- Load-use costs exactly 1 bubble. The next cycle, the LW has left ID/EX, so the stall clears.
- Taken-branch penalty: 1 squashed slot.
- halted is asserted after the edge that accepts HLT.
- rst=1 at an edge:
  - All ex_* = 0, branch_taken = 0, branch_target = 0, halted = 0, state = RUN.
  - The register file is cleared to 0.
  - rst overrides wb_we in the same cycle.
- Mid-operation reset discards any pending stall, branch pulse or halt.
- Simultaneous events:
  - Squash beats stall.
  - Stall beats branch and halt.
  - Write-back to a register on the same edge that ID reads it is visible through write-through.

## Test plan
- Reset, then ADD R3,R1,R2 with R1=5, R2=7 (preloaded via wb) → after 1 edge: ex_valid=1, ex_rs_data=5, ex_rt_data=7, ex_regwrite=1, ex_dst=3.
- LW R4,R1,2 followed by ADD R5,R4,R2 → stall_out=1 for exactly 1 cycle and one bubble (ex_valid=0); ADD issues on the next edge; same test with ADD R5,R6,R2 → no stall.
- Write-through: wb_we=1, wb_dst=2, wb_data=0x00AB in the same cycle as SUB reading R2 → ex_rt_data=0x00AB. A write to R0 → R0 still reads 0.
- B cond=001 offset 0x1FF with pc_plus2=0x0010, Z=1 → branch_taken=1, branch_target=0x000E; next slot squashed (ex_valid=0). Same with Z=0 → no pulse, next slot issues.
- BR cond=111 using R7=0x1234 immediately after LW R7 → 1 stall, then branch_taken=1 with target 0x1234.
- HLT → halted=1 and stall_out=1 held for 10 cycles; rst=1 → halted=0, all outputs 0. Repeat with DATA_W=32, NREG=8: reading R9 returns 0, and the branch target wraps modulo 2^32.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// IF/ID inputs, write-back port and ID/EX outputs of the decode stage.
interface id_stage_pipe_if #(parameter int DATA_W = 16);
  logic [15:0]       instr;
  logic [DATA_W-1:0] pc_plus2;
  logic              id_valid;
  logic [2:0]        flags;
  logic              wb_we;
  logic [3:0]        wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              stall_out;
  logic              ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic              ex_memtoreg, ex_alusrc, ex_llb, ex_lhb;
  logic [3:0]        ex_aluop;
  logic [3:0]        ex_dst;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;
  logic              halted;

  modport master (
    output instr, pc_plus2, id_valid, flags, wb_we, wb_dst, wb_data,
    input  stall_out, ex_valid, ex_memread, ex_memwrite, ex_regwrite,
           ex_memtoreg, ex_alusrc, ex_llb, ex_lhb, ex_aluop, ex_dst,
           ex_rs_data, ex_rt_data, ex_imm, branch_taken, branch_target, halted
  );

  modport slave (
    input  instr, pc_plus2, id_valid, flags, wb_we, wb_dst, wb_data,
    output stall_out, ex_valid, ex_memread, ex_memwrite, ex_regwrite,
           ex_memtoreg, ex_alusrc, ex_llb, ex_lhb, ex_aluop, ex_dst,
           ex_rs_data, ex_rt_data, ex_imm, branch_taken, branch_target, halted
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, control decode, branch resolve, ID/EX register, load-use interlock, halt.
// One cycle to ex_*; stall_out (combinational) holds IF/ID on load-use or halt.
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input logic          clk,
  input logic          rst,
  id_stage_pipe_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        op, rs_idx, rt_idx;
  logic              uses_rs, uses_rt, is_b, is_br, cond_ok;
  logic              eff, hazard, issue, take;
  logic [DATA_W-1:0] rs_val, rt_val, imm, b_target;
  logic              flag_n, flag_v, flag_z;

  assign op     = bus.instr[15:12];
  assign is_b   = (op == 4'b1100);
  assign is_br  = (op == 4'b1101);
  assign flag_n = bus.flags[2];
  assign flag_v = bus.flags[1];
  assign flag_z = bus.flags[0];

  always_comb begin
    rs_idx = bus.instr[7:4];
    rt_idx = bus.instr[3:0];
    if (op == 4'b1010 || op == 4'b1011) rs_idx = bus.instr[11:8];
    if (op[3:1] == 3'b100)              rt_idx = bus.instr[11:8];
    uses_rs = !(op == 4'b1100 || op == 4'b1110 || op == 4'b1111);
    uses_rt = (op <= 4'b0011) || (op == 4'b0111) || (op == 4'b1001);
  end

  // R0 and indices beyond NREG fall through to 0; write-back bypasses the array.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs_idx == i[3:0])
        rs_val = (bus.wb_we && bus.wb_dst == rs_idx) ? bus.wb_data : regs[i];
      if (rt_idx == i[3:0])
        rt_val = (bus.wb_we && bus.wb_dst == rt_idx) ? bus.wb_data : regs[i];
    end
  end

  always_comb begin
    if ((op >= 4'b0100 && op <= 4'b0110) || op[3:1] == 3'b100)
      imm = {{(DATA_W-4){bus.instr[3]}}, bus.instr[3:0]};
    else
      imm = {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]};
  end

  always_comb begin
    cond_ok = 1'b0;
    case (bus.instr[11:9])
      3'b000: cond_ok = !flag_z;
      3'b001: cond_ok = flag_z;
      3'b010: cond_ok = !flag_z && !flag_n;
      3'b011: cond_ok = flag_n;
      3'b100: cond_ok = flag_z || !flag_n;
      3'b101: cond_ok = flag_z || flag_n;
      3'b110: cond_ok = flag_v;
      default: cond_ok = 1'b1;
    endcase
  end

  assign b_target = bus.pc_plus2 + {{(DATA_W-10){bus.instr[8]}}, bus.instr[8:0], 1'b0};

  // A squashed wrong-path slot must not stall, branch or halt.
  assign eff    = bus.id_valid && !bus.branch_taken && (state == RUN);
  assign hazard = eff && bus.ex_valid && bus.ex_memread && (bus.ex_dst != 4'd0) &&
                  ((uses_rs && bus.ex_dst == rs_idx) || (uses_rt && bus.ex_dst == rt_idx));
  assign bus.stall_out = hazard || (state == HALT);
  assign issue  = eff && !bus.stall_out;
  assign take   = issue && (is_b || is_br) && cond_ok;
  assign bus.halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && issue && op == 4'b1111) state_nxt = HALT;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst)
        regs[i] <= '0;
      else if (i != 0 && bus.wb_we && bus.wb_dst == i[3:0])
        regs[i] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_memread    <= 1'b0;
      bus.ex_memwrite   <= 1'b0;
      bus.ex_regwrite   <= 1'b0;
      bus.ex_memtoreg   <= 1'b0;
      bus.ex_alusrc     <= 1'b0;
      bus.ex_llb        <= 1'b0;
      bus.ex_lhb        <= 1'b0;
      bus.ex_aluop      <= 4'd0;
      bus.ex_dst        <= 4'd0;
      bus.ex_rs_data    <= '0;
      bus.ex_rt_data    <= '0;
      bus.ex_imm        <= '0;
      bus.branch_taken  <= 1'b0;
      bus.branch_target <= '0;
    end else begin
      bus.ex_valid     <= issue;
      bus.ex_memread   <= issue && op == 4'b1000;
      bus.ex_memwrite  <= issue && op == 4'b1001;
      bus.ex_regwrite  <= issue && (op <= 4'b1000 || op == 4'b1010 ||
                                    op == 4'b1011 || op == 4'b1110);
      bus.ex_memtoreg  <= issue && op == 4'b1000;
      bus.ex_alusrc    <= issue && ((op >= 4'b0100 && op <= 4'b0110) ||
                                    (op >= 4'b1000 && op <= 4'b1011));
      bus.ex_llb       <= issue && op == 4'b1010;
      bus.ex_lhb       <= issue && op == 4'b1011;
      bus.ex_aluop     <= issue ? op : 4'd0;
      bus.ex_dst       <= issue ? bus.instr[11:8] : 4'd0;
      if (issue) begin
        bus.ex_rs_data <= rs_val;
        bus.ex_rt_data <= rt_val;
        bus.ex_imm     <= imm;
      end
      bus.branch_taken <= take;
      if (take) bus.branch_target <= is_br ? rs_val : b_target;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboarded bench for id_stage_pipe: a 16-bit/16-reg and a 32-bit/8-reg instance.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(16)) b1 ();
  id_stage_pipe_if #(.DATA_W(32)) b2 ();

  id_stage_pipe #(.DATA_W(16), .NREG(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  id_stage_pipe #(.DATA_W(32), .NREG(8))  dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [31:0] rs, rt, imm;
    logic [6:0]  ctl;  // {memread, memwrite, regwrite, memtoreg, alusrc, llb, lhb}
  } exp_t;

  localparam logic [6:0] C_ALU  = 7'b0010000;
  localparam logic [6:0] C_LW   = 7'b1011100;
  localparam logic [6:0] C_NONE = 7'b0000000;

  exp_t        q1[$], q2[$];
  logic [31:0] bq1[$], bq2[$];
  exp_t        e1, e2;
  logic [31:0] t1, t2;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [3:0] dst, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] imm, input logic [6:0] ctl);
    exp_t e;
    e.op = op; e.dst = dst; e.rs = rs; e.rt = rt; e.imm = imm; e.ctl = ctl;
    return e;
  endfunction

  task automatic cmp_ex(input string tag, input exp_t e, input logic [3:0] op, input logic [3:0] dst,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                        input logic [6:0] ctl);
    chk({tag, "_aluop"}, 32'(op), 32'(e.op));
    chk({tag, "_dst"}, 32'(dst), 32'(e.dst));
    chk({tag, "_rs_data"}, rs, e.rs);
    chk({tag, "_rt_data"}, rt, e.rt);
    chk({tag, "_imm"}, imm, e.imm);
    chk({tag, "_ctl"}, 32'(ctl), 32'(e.ctl));
  endtask

  // Monitors: every issued instruction and every branch pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.ex_valid) begin
        if (q1.size() == 0) chk("dut1_unexpected_issue", 32'(b1.ex_valid), 32'd0);
        else begin
          e1 = q1.pop_front();
          cmp_ex("dut1", e1, b1.ex_aluop, b1.ex_dst, 32'(b1.ex_rs_data), 32'(b1.ex_rt_data),
                 32'(b1.ex_imm), {b1.ex_memread, b1.ex_memwrite, b1.ex_regwrite, b1.ex_memtoreg,
                                  b1.ex_alusrc, b1.ex_llb, b1.ex_lhb});
        end
      end
      if (b1.branch_taken) begin
        if (bq1.size() == 0) chk("dut1_unexpected_branch", 32'(b1.branch_taken), 32'd0);
        else begin
          t1 = bq1.pop_front();
          chk("dut1_branch_target", 32'(b1.branch_target), t1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b2.ex_valid) begin
        if (q2.size() == 0) chk("dut2_unexpected_issue", 32'(b2.ex_valid), 32'd0);
        else begin
          e2 = q2.pop_front();
          cmp_ex("dut2", e2, b2.ex_aluop, b2.ex_dst, b2.ex_rs_data, b2.ex_rt_data, b2.ex_imm,
                 {b2.ex_memread, b2.ex_memwrite, b2.ex_regwrite, b2.ex_memtoreg,
                  b2.ex_alusrc, b2.ex_llb, b2.ex_lhb});
        end
      end
      if (b2.branch_taken) begin
        if (bq2.size() == 0) chk("dut2_unexpected_branch", 32'(b2.branch_taken), 32'd0);
        else begin
          t2 = bq2.pop_front();
          chk("dut2_branch_target", b2.branch_target, t2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic [15:0] ins, input logic vld, input logic exp_stall);
    b1.instr = ins;
    b1.id_valid = vld;
    #1 chk("dut1_stall_out", 32'(b1.stall_out), 32'(exp_stall));
    tick();
  endtask

  task automatic step2(input logic [15:0] ins, input logic vld, input logic exp_stall);
    b2.instr = ins;
    b2.id_valid = vld;
    #1 chk("dut2_stall_out", 32'(b2.stall_out), 32'(exp_stall));
    tick();
  endtask

  task automatic wr1(input logic [3:0] dst, input logic [15:0] data);
    b1.id_valid = 1'b0;
    b1.wb_we = 1'b1; b1.wb_dst = dst; b1.wb_data = data;
    tick();
    b1.wb_we = 1'b0;
  endtask

  task automatic wr2(input logic [3:0] dst, input logic [31:0] data);
    b2.id_valid = 1'b0;
    b2.wb_we = 1'b1; b2.wb_dst = dst; b2.wb_data = data;
    tick();
    b2.wb_we = 1'b0;
  endtask

  task automatic reset_chk1();
    chk("rst_ctl", 32'({b1.ex_valid, b1.ex_memread, b1.ex_memwrite, b1.ex_regwrite, b1.ex_memtoreg,
                        b1.ex_alusrc, b1.ex_llb, b1.ex_lhb, b1.ex_aluop, b1.ex_dst}), 32'd0);
    chk("rst_data", {b1.ex_rs_data, b1.ex_rt_data}, 32'd0);
    chk("rst_imm", 32'(b1.ex_imm), 32'd0);
    chk("rst_branch", 32'({b1.branch_taken, b1.branch_target}), 32'd0);
    chk("rst_halted", 32'(b1.halted), 32'd0);
    chk("rst_stall", 32'(b1.stall_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    b1.instr = '0; b1.pc_plus2 = '0; b1.id_valid = 0; b1.flags = '0;
    b1.wb_we = 0; b1.wb_dst = '0; b1.wb_data = '0;
    b2.instr = '0; b2.pc_plus2 = '0; b2.id_valid = 0; b2.flags = '0;
    b2.wb_we = 0; b2.wb_dst = '0; b2.wb_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    reset_chk1();
    chk("dut2_rst_ctl", 32'({b2.ex_valid, b2.branch_taken, b2.halted}), 32'd0);

    wr1(4'd1, 16'd5);
    wr1(4'd2, 16'd7);
    wr1(4'd7, 16'h1234);
    b1.pc_plus2 = 16'h0100;

    // ADD R3,R1,R2
    q1.push_back(mk(4'h0, 4'd3, 32'd5, 32'd7, 32'h12, C_ALU));
    step1(16'h0312, 1, 0);

    // LW R4,R1,2 then dependent ADD R5,R4,R2: one stall, one bubble
    q1.push_back(mk(4'h8, 4'd4, 32'd5, 32'd0, 32'd2, C_LW));
    step1(16'h8412, 1, 0);
    step1(16'h0542, 1, 1);
    chk("lu_bubble", 32'(b1.ex_valid), 32'd0);
    q1.push_back(mk(4'h0, 4'd5, 32'd0, 32'd7, 32'h42, C_ALU));
    step1(16'h0542, 1, 0);

    // LW R4 then independent ADD R5,R6,R2: no stall
    q1.push_back(mk(4'h8, 4'd4, 32'd5, 32'd0, 32'd2, C_LW));
    step1(16'h8412, 1, 0);
    q1.push_back(mk(4'h0, 4'd5, 32'd0, 32'd7, 32'h62, C_ALU));
    step1(16'h0562, 1, 0);

    // SUB R3,R1,R2 with same-cycle write-back of R2
    b1.wb_we = 1; b1.wb_dst = 4'd2; b1.wb_data = 16'h00AB;
    q1.push_back(mk(4'h1, 4'd3, 32'd5, 32'hAB, 32'h12, C_ALU));
    step1(16'h1312, 1, 0);

    // Writes to R0 are ignored, both bypassed and stored
    b1.wb_we = 1; b1.wb_dst = 4'd0; b1.wb_data = 16'h5555;
    q1.push_back(mk(4'h0, 4'd3, 32'd0, 32'd5, 32'h01, C_ALU));
    step1(16'h0301, 1, 0);
    b1.wb_we = 0;
    q1.push_back(mk(4'h0, 4'd3, 32'd0, 32'd5, 32'h01, C_ALU));
    step1(16'h0301, 1, 0);

    // B cond=001 offset -1, Z=1: taken to 0x000E, next slot squashed
    b1.pc_plus2 = 16'h0010; b1.flags = 3'b001;
    q1.push_back(mk(4'hC, 4'd3, 32'd0, 32'd0, 32'hFFFF, C_NONE));
    bq1.push_back(32'h000E);
    step1(16'hC3FF, 1, 0);
    chk("b_taken_pulse", 32'(b1.branch_taken), 32'd1);
    step1(16'h0312, 1, 0);
    chk("b_squash", 32'(b1.ex_valid), 32'd0);
    chk("b_pulse_end", 32'(b1.branch_taken), 32'd0);
    q1.push_back(mk(4'h0, 4'd3, 32'd5, 32'hAB, 32'h12, C_ALU));
    step1(16'h0312, 1, 0);

    // Same branch with Z=0: not taken, next slot issues
    b1.flags = 3'b000;
    q1.push_back(mk(4'hC, 4'd3, 32'd0, 32'd0, 32'hFFFF, C_NONE));
    step1(16'hC3FF, 1, 0);
    chk("b_not_taken", 32'(b1.branch_taken), 32'd0);
    q1.push_back(mk(4'h0, 4'd3, 32'd5, 32'hAB, 32'h12, C_ALU));
    step1(16'h0312, 1, 0);

    // LW R7 then BR always via R7: one stall, then taken to 0x1234
    q1.push_back(mk(4'h8, 4'd7, 32'd5, 32'h1234, 32'd0, C_LW));
    step1(16'h8710, 1, 0);
    step1(16'hDE70, 1, 1);
    q1.push_back(mk(4'hD, 4'hE, 32'h1234, 32'd0, 32'h70, C_NONE));
    bq1.push_back(32'h1234);
    step1(16'hDE70, 1, 0);
    chk("br_taken_pulse", 32'(b1.branch_taken), 32'd1);
    step1(16'h0312, 1, 0);
    chk("br_squash", 32'(b1.ex_valid), 32'd0);

    // HLT issues, then halted and stall_out held
    q1.push_back(mk(4'hF, 4'd0, 32'd0, 32'd0, 32'd0, C_NONE));
    step1(16'hF000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("halted_held", 32'(b1.halted), 32'd1);
      step1(16'h0312, 1, 1);
    end

    // Reset overrides a concurrent write-back and clears the register file
    b1.wb_we = 1; b1.wb_dst = 4'd1; b1.wb_data = 16'h7777;
    b1.id_valid = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b1.wb_we = 0;
    reset_chk1();
    q1.push_back(mk(4'h0, 4'd3, 32'd0, 32'd0, 32'h12, C_ALU));
    step1(16'h0312, 1, 0);
    b1.id_valid = 0;

    // 32-bit, 8-register instance: R9 out of range, branch target wraps
    wr2(4'd1, 32'h11);
    wr2(4'd9, 32'h99);
    q2.push_back(mk(4'h0, 4'd3, 32'd0, 32'h11, 32'hFFFFFF91, C_ALU));
    step2(16'h0391, 1, 0);
    b2.pc_plus2 = 32'hFFFFFFFE;
    q2.push_back(mk(4'hC, 4'hE, 32'd0, 32'd0, 32'd3, C_NONE));
    bq2.push_back(32'h00000004);
    step2(16'hCE03, 1, 0);
    chk("dut2_b_pulse", 32'(b2.branch_taken), 32'd1);
    step2(16'h0391, 1, 0);
    chk("dut2_squash", 32'(b2.ex_valid), 32'd0);
    b2.id_valid = 0;

    tick();
    tick();
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("bq1_drained", 32'(bq1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("bq2_drained", 32'(bq2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
